commit_trace_buffer: RTL and testbench

COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

---
 rtl/trace_pkg.sv | 41 ++++
 rtl/trace_fifo.sv | 97 +++++++++
 rtl/commit_trace_buffer.sv | 251 +++++++++++++++++++++++++
 tb/tb_commit_trace_buffer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// ---------------------------------------------------------------------------
// trace_pkg
// Shared constants, trace-entry record and helper function for the commit
// trace buffer.
//   TS_W          : timestamp / cycle-counter width
//   DROP_W        : dropped-event counter width
//   CH_MAX_W      : widest channel index (up to 8 channels)
//   FIELD_MAX_W   : widest pc/addr/data field the record can carry
//   trace_entry_t : one trace record (ch, pc, addr, data, ts). Fields are
//                   sized for the widest configuration. Narrower instances
//                   zero-extend into the record and truncate back out of it.
//   drop_sat_add  : saturating add used by the drop counter
// ---------------------------------------------------------------------------
package trace_pkg;

  localparam int TS_W        = 32;
  localparam int DROP_W      = 16;
  localparam int CH_MAX_W    = 3;
  localparam int FIELD_MAX_W = 64;

  typedef struct packed {
    logic [CH_MAX_W-1:0]    ch;
    logic [FIELD_MAX_W-1:0] pc;
    logic [FIELD_MAX_W-1:0] addr;
    logic [FIELD_MAX_W-1:0] data;
    logic [TS_W-1:0]        ts;
  } trace_entry_t;

  // Add up to 15 events to the drop counter and stick at all-ones.
  function automatic logic [DROP_W-1:0] drop_sat_add(input logic [DROP_W-1:0] cnt,
                                                     input logic [3:0]        inc);
    logic [DROP_W:0] sum;
    sum = {1'b0, cnt} + {{(DROP_W-3){1'b0}}, inc};
    if (sum[DROP_W]) begin
      drop_sat_add = {DROP_W{1'b1}};
    end else begin
      drop_sat_add = sum[DROP_W-1:0];
    end
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// ---------------------------------------------------------------------------
// trace_fifo
// Show-ahead FIFO that stores trace entries. rdata_o always presents the head
// entry. A push into a full FIFO is accepted only when a pop happens on the
// same edge. flush_i empties the FIFO and takes priority over push and pop.
// Parameters:
//   DEPTH : number of entries, a power of two and at least 2
//   W     : entry width in bits
// Ports:
//   clk_i    : clock, rising edge
//   rst_i    : asynchronous active-high reset
//   flush_i  : synchronous clear
//   push_i   : write wdata_i at the tail
//   wdata_i  : entry to write
//   pop_i    : remove the head entry (ignored when empty)
//   rdata_o  : head entry
//   level_o  : occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [W-1:0]           wdata_i,
  input  logic                   pop_i,
  output logic [W-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW:0]   level_q, level_d;
  logic          do_pop_s;
  logic          do_push_s;

  assign do_pop_s  = pop_i && (level_q != '0) && !flush_i;
  assign do_push_s = push_i && !flush_i && ((level_q != (PW+1)'(DEPTH)) || do_pop_s);

  // Next-state pointers and level.
  // The pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (do_push_s) begin
        wptr_d = wptr_q + PW'(1);
      end else begin
        wptr_d = wptr_q;
      end
      if (do_pop_s) begin
        rptr_d = rptr_q + PW'(1);
      end else begin
        rptr_d = rptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   level_d = level_q + (PW+1)'(1);
        2'b01:   level_d = level_q - (PW+1)'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Pointer and level registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Entry storage. It has no reset because level_q alone decides validity.
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/commit_trace_buffer.sv
// ---------------------------------------------------------------------------
// commit_trace_buffer
// Captures per-channel commit events (ch0 = register writeback,
// ch1 = memory store, ...) into one-deep pending slots. It then moves at most
// one pending slot per cycle, in round-robin order, into a show-ahead trace
// FIFO. The FIFO is read out through a valid/ready handshake.
// Optional feature: define TRACE_TIMESTAMP_EN to keep a free-running 32-bit
// cycle counter and store each event's capture cycle with the entry.
// Without it, no counter or timestamp storage exists and out_ts is tied to 0.
// Parameters: NCH (1..8 channels), DEPTH (FIFO entries, power of two, >= 2),
//             PCW/AW/DW (pc/addr/data widths, at most 64 each).
// Ports:
//   clk, rst           : clock (rising edge), asynchronous active-high reset
//   ev_valid[NCH]      : per-channel event strobe, already qualified
//   ev_pc/addr/data    : packed per-channel payload, channel i in slice i
//   flush              : drop everything buffered plus this cycle's events
//   out_valid/out_ready: readout handshake. A pop happens when both are high.
//   out_ch..out_ts     : head entry. Only meaningful while out_valid is high.
//   level              : FIFO occupancy
//   drop_cnt           : saturating count of events lost to a busy slot
// ---------------------------------------------------------------------------
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int DEPTH = 16,
  parameter int PCW   = 32,
  parameter int AW    = 32,
  parameter int DW    = 32,
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         ev_valid,
  input  logic [NCH*PCW-1:0]     ev_pc,
  input  logic [NCH*AW-1:0]      ev_addr,
  input  logic [NCH*DW-1:0]      ev_data,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CHW-1:0]         out_ch,
  output logic [PCW-1:0]         out_pc,
  output logic [AW-1:0]          out_addr,
  output logic [DW-1:0]          out_data,
  output logic [TS_W-1:0]        out_ts,
  output logic [$clog2(DEPTH):0] level,
  output logic [DROP_W-1:0]      drop_cnt
);

  localparam int LW = $clog2(DEPTH) + 1;
`ifdef TRACE_TIMESTAMP_EN
  localparam int EN_TS_W = TS_W;
`else
  localparam int EN_TS_W = 0;
`endif
  // FIFO entry layout from MSB down: ch | pc | addr | data | ts (optional).
  localparam int OFF_DATA = EN_TS_W;
  localparam int OFF_ADDR = OFF_DATA + DW;
  localparam int OFF_PC   = OFF_ADDR + AW;
  localparam int OFF_CH   = OFF_PC + PCW;
  localparam int ENTRY_W  = OFF_CH + CHW;

  logic [NCH-1:0]    pend_vld_q, pend_vld_d;
  logic [PCW-1:0]    pend_pc_q   [NCH];
  logic [PCW-1:0]    pend_pc_d   [NCH];
  logic [AW-1:0]     pend_addr_q [NCH];
  logic [AW-1:0]     pend_addr_d [NCH];
  logic [DW-1:0]     pend_data_q [NCH];
  logic [DW-1:0]     pend_data_d [NCH];
`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0]   pend_ts_q   [NCH];
  logic [TS_W-1:0]   pend_ts_d   [NCH];
  logic [TS_W-1:0]   cnt_q;
`endif

  logic [CHW-1:0]    rr_q, rr_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [3:0]        n_drop_s;

  logic [CHW-1:0]    cand_s;
  logic [CHW-1:0]    grant_idx_s;
  logic              grant_vld_s;
  logic [NCH-1:0]    grant_oh_s;

  logic [LW-1:0]     level_s;
  logic              full_s;
  logic              pop_s;
  logic              can_push_s;
  logic [ENTRY_W-1:0] wdata_s;
  logic [ENTRY_W-1:0] rdata_s;
  trace_entry_t      head_s;

  assign out_valid  = (level_s != '0);
  assign pop_s      = out_valid && out_ready;
  assign full_s     = (level_s == LW'(DEPTH));
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign can_push_s = !full_s || pop_s;

`ifdef TRACE_TIMESTAMP_EN
  // Free-running cycle counter. Each event is stamped with the value it holds
  // at the capturing edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + TS_W'(1);
    end
  end
`endif

  // Round-robin pick of one pending slot, searching from rr_q upward.
  // A flush edge grants nothing, so the pointer stays where it was.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    cand_s      = '0;
    for (int i = 0; i < NCH; i++) begin
      cand_s = CHW'((int'(rr_q) + i) % NCH);
      if (!grant_vld_s && pend_vld_q[cand_s] && can_push_s && !flush) begin
        grant_vld_s = 1'b1;
        grant_idx_s = cand_s;
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  // One-hot form of the grant for the per-slot update.
  always_comb begin
    grant_oh_s = '0;
    for (int i = 0; i < NCH; i++) begin
      grant_oh_s[i] = grant_vld_s && (grant_idx_s == CHW'(i));
    end
  end

  // Next search starts at the channel after the last grant.
  always_comb begin
    rr_d = rr_q;
    if (grant_vld_s) begin
      if (int'(grant_idx_s) == NCH - 1) begin
        rr_d = '0;
      end else begin
        rr_d = grant_idx_s + CHW'(1);
      end
    end else begin
      rr_d = rr_q;
    end
  end

  // Pending-slot update. A slot accepts a new event when it is empty or is
  // being granted this edge. Otherwise the event is lost and counted.
  always_comb begin
    pend_vld_d  = pend_vld_q;
    pend_pc_d   = pend_pc_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
`ifdef TRACE_TIMESTAMP_EN
    pend_ts_d   = pend_ts_q;
`endif
    n_drop_s    = '0;
    for (int i = 0; i < NCH; i++) begin
      if (flush) begin
        pend_vld_d[i] = 1'b0;
      end else if (ev_valid[i] && (!pend_vld_q[i] || grant_oh_s[i])) begin
        pend_vld_d[i]  = 1'b1;
        pend_pc_d[i]   = ev_pc[i*PCW +: PCW];
        pend_addr_d[i] = ev_addr[i*AW +: AW];
        pend_data_d[i] = ev_data[i*DW +: DW];
`ifdef TRACE_TIMESTAMP_EN
        pend_ts_d[i]   = cnt_q;
`endif
      end else if (ev_valid[i]) begin
        n_drop_s = n_drop_s + 4'd1;
      end else if (grant_oh_s[i]) begin
        pend_vld_d[i] = 1'b0;
      end else begin
        pend_vld_d[i] = pend_vld_q[i];
      end
    end
    drop_d = drop_sat_add(drop_q, n_drop_s);
  end

  // Pending slots, round-robin pointer and drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld_q  <= '0;
      pend_pc_q   <= '{default: '0};
      pend_addr_q <= '{default: '0};
      pend_data_q <= '{default: '0};
`ifdef TRACE_TIMESTAMP_EN
      pend_ts_q   <= '{default: '0};
`endif
      rr_q        <= '0;
      drop_q      <= '0;
    end else begin
      pend_vld_q  <= pend_vld_d;
      pend_pc_q   <= pend_pc_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
`ifdef TRACE_TIMESTAMP_EN
      pend_ts_q   <= pend_ts_d;
`endif
      rr_q        <= rr_d;
      drop_q      <= drop_d;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  assign wdata_s = {grant_idx_s, pend_pc_q[grant_idx_s], pend_addr_q[grant_idx_s],
                    pend_data_q[grant_idx_s], pend_ts_q[grant_idx_s]};
`else
  assign wdata_s = {grant_idx_s, pend_pc_q[grant_idx_s], pend_addr_q[grant_idx_s],
                    pend_data_q[grant_idx_s]};
`endif

  trace_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .push_i  (grant_vld_s),
    .wdata_i (wdata_s),
    .pop_i   (pop_s),
    .rdata_o (rdata_s),
    .level_o (level_s)
  );

  // Unpack the head entry into the shared record. ts stays zero when
  // timestamps are not stored.
  always_comb begin
    head_s      = '0;
    head_s.ch   = CH_MAX_W'(rdata_s[OFF_CH +: CHW]);
    head_s.pc   = FIELD_MAX_W'(rdata_s[OFF_PC +: PCW]);
    head_s.addr = FIELD_MAX_W'(rdata_s[OFF_ADDR +: AW]);
    head_s.data = FIELD_MAX_W'(rdata_s[OFF_DATA +: DW]);
`ifdef TRACE_TIMESTAMP_EN
    head_s.ts   = rdata_s[0 +: TS_W];
`endif
  end

  assign out_ch   = CHW'(head_s.ch);
  assign out_pc   = PCW'(head_s.pc);
  assign out_addr = AW'(head_s.addr);
  assign out_data = DW'(head_s.data);
  assign out_ts   = head_s.ts;
  assign level    = level_s;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// ---------------------------------------------------------------------------
// tb_commit_trace_buffer
// Directed self-checking bench for commit_trace_buffer (NCH=2, DEPTH=4).
// Inputs change on the falling edge. Outputs are sampled on the falling edge.
// Edge numbering after reset release: e0 is the first rising edge, so the
// cycle counter holds k just before edge k.
// ---------------------------------------------------------------------------
module tb_commit_trace_buffer;

  localparam int NCH   = 2;
  localparam int DEPTH = 4;
  localparam int PCW   = 32;
  localparam int AW    = 32;
  localparam int DW    = 32;
`ifdef TRACE_TIMESTAMP_EN
  localparam logic TS_ON = 1'b1;
`else
  localparam logic TS_ON = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [NCH-1:0]     ev_valid;
  logic [NCH*PCW-1:0] ev_pc;
  logic [NCH*AW-1:0]  ev_addr;
  logic [NCH*DW-1:0]  ev_data;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [0:0]         out_ch;
  logic [PCW-1:0]     out_pc;
  logic [AW-1:0]      out_addr;
  logic [DW-1:0]      out_data;
  logic [31:0]        out_ts;
  logic [2:0]         level;
  logic [15:0]        drop_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  commit_trace_buffer #(
    .NCH(NCH), .DEPTH(DEPTH), .PCW(PCW), .AW(AW), .DW(DW)
  ) dut (
    .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_pc(ev_pc), .ev_addr(ev_addr),
    .ev_data(ev_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_pc(out_pc), .out_addr(out_addr), .out_data(out_data),
    .out_ts(out_ts), .level(level), .drop_cnt(drop_cnt)
  );

  task automatic clear_ev();
    ev_valid = '0;
    ev_pc    = '0;
    ev_addr  = '0;
    ev_data  = '0;
  endtask

  task automatic set_ev(input int ch, input logic [31:0] pc, input logic [31:0] addr,
                        input logic [31:0] data);
    ev_valid[ch]         = 1'b1;
    ev_pc[ch*PCW +: PCW] = pc;
    ev_addr[ch*AW +: AW] = addr;
    ev_data[ch*DW +: DW] = data;
  endtask

  // Holds reset for two edges and releases it on a falling edge.
  task automatic do_reset();
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    clear_ev();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
    total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL reset_drop got=%0d want=0", drop_cnt); end
  endtask

  // ch0 event at e5 is written at e6 and is visible after e6, stamped 5.
  task automatic test_single_event();
    logic [31:0] exp_ts;
    exp_ts = TS_ON ? 32'd5 : 32'd0;
    do_reset();
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    set_ev(0, 32'd4, 32'd3, 32'd7);
    @(negedge clk);
    clear_ev();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%0b want=0", out_valid); end
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b want=1", out_valid); end
    total++; if (out_ch !== 1'b0) begin bad++; $display("FAIL single_ch got=%0d want=0", out_ch); end
    total++; if (out_pc !== 32'd4) begin bad++; $display("FAIL single_pc got=%0d want=4", out_pc); end
    total++; if (out_addr !== 32'd3) begin bad++; $display("FAIL single_addr got=%0d want=3", out_addr); end
    total++; if (out_data !== 32'd7) begin bad++; $display("FAIL single_data got=%0d want=7", out_data); end
    total++; if (out_ts !== exp_ts) begin bad++; $display("FAIL single_ts got=%0d want=%0d", out_ts, exp_ts); end
    @(negedge clk);
    total++; if (level !== 3'd0) begin bad++; $display("FAIL single_popped_level got=%0d want=0", level); end
    out_ready = 1'b0;
  endtask

  // Paired events at e0, e2 and e4 with out_ready=1. The grants alternate.
  task automatic test_dual_channel();
    logic        got_ch[$];
    logic [31:0] got_data[$];
    logic [31:0] exp_data[6];
    logic        exp_ch[6];
    exp_data = '{32'd0, 32'd1, 32'd4, 32'd5, 32'd8, 32'd9};
    exp_ch   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (out_valid) begin
        got_ch.push_back(out_ch[0]);
        got_data.push_back(out_data);
      end
      clear_ev();
      if (c == 0 || c == 2 || c == 4) begin
        set_ev(0, 32'(100 + c), 32'd0, 32'(c * 2));
        set_ev(1, 32'(200 + c), 32'd0, 32'(c * 2 + 1));
      end
      @(negedge clk);
    end
    total++; if (got_data.size() !== 6) begin bad++; $display("FAIL dual_count got=%0d want=6", got_data.size()); end
    for (int j = 0; j < 6 && j < got_data.size(); j++) begin
      total++; if (got_ch[j] !== exp_ch[j]) begin bad++; $display("FAIL dual_ch[%0d] got=%0d want=%0d", j, got_ch[j], exp_ch[j]); end
      total++; if (got_data[j] !== exp_data[j]) begin bad++; $display("FAIL dual_data[%0d] got=%0d want=%0d", j, got_data[j], exp_data[j]); end
    end
    total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL dual_drop got=%0d want=0", drop_cnt); end
    out_ready = 1'b0;
  endtask

  // 8 back-to-back ch0 events into a 4-deep FIFO: 4 stored, 1 pending,
  // 3 dropped. The drain then sees a push and a pop on a full FIFO.
  task automatic test_full_drop();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      clear_ev();
      set_ev(0, 32'(100 + i), 32'(i), 32'(i));
      @(negedge clk);
    end
    clear_ev();
    total++; if (level !== 3'd4) begin bad++; $display("FAIL full_level got=%0d want=4", level); end
    total++; if (drop_cnt !== 16'd3) begin bad++; $display("FAIL full_drop got=%0d want=3", drop_cnt); end
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL drain_valid[%0d] got=%0b want=1", j, out_valid); end
      total++; if (out_pc !== 32'(100 + j)) begin bad++; $display("FAIL drain_pc[%0d] got=%0d want=%0d", j, out_pc, 100 + j); end
      @(negedge clk);
      if (j == 0) begin
        total++; if (level !== 3'd4) begin bad++; $display("FAIL full_push_pop_level got=%0d want=4", level); end
      end
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%0b want=0", out_valid); end
    out_ready = 1'b0;
  endtask

  // Flush with 3 entries and one pending event. The drop count is kept from
  // the previous test and must not change.
  task automatic test_flush();
    for (int i = 0; i < 4; i++) begin
      clear_ev();
      set_ev(0, 32'(200 + i), 32'd0, 32'd0);
      @(negedge clk);
    end
    clear_ev();
    total++; if (level !== 3'd3) begin bad++; $display("FAIL flush_pre_level got=%0d want=3", level); end
    flush = 1'b1;
    set_ev(0, 32'd299, 32'd0, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    clear_ev();
    total++; if (level !== 3'd0) begin bad++; $display("FAIL flush_level got=%0d want=0", level); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b want=0", out_valid); end
    total++; if (drop_cnt !== 16'd3) begin bad++; $display("FAIL flush_drop got=%0d want=3", drop_cnt); end
    set_ev(1, 32'h55, 32'h66, 32'h77);
    @(negedge clk);
    clear_ev();
    @(negedge clk);
    @(negedge clk);
    total++; if (level !== 3'd1) begin bad++; $display("FAIL post_flush_level got=%0d want=1", level); end
    total++; if (out_ch !== 1'b1) begin bad++; $display("FAIL post_flush_ch got=%0d want=1", out_ch); end
    total++; if (out_pc !== 32'h55) begin bad++; $display("FAIL post_flush_pc got=%0h want=55", out_pc); end
    total++; if (out_addr !== 32'h66) begin bad++; $display("FAIL post_flush_addr got=%0h want=66", out_addr); end
    total++; if (out_data !== 32'h77) begin bad++; $display("FAIL post_flush_data got=%0h want=77", out_data); end
  endtask

  // Reset in the middle of a cycle with entries, a pending slot and drops.
  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) begin
      clear_ev();
      set_ev(0, 32'(300 + i), 32'd0, 32'd0);
      @(negedge clk);
    end
    clear_ev();
    total++; if (level !== 3'd3) begin bad++; $display("FAIL mid_pre_level got=%0d want=3", level); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%0b want=0", out_valid); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL mid_rst_level got=%0d want=0", level); end
    total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL mid_rst_drop got=%0d want=0", drop_cnt); end
    if (!TS_ON) begin
      total++; if (out_ts !== 32'd0) begin bad++; $display("FAIL mid_rst_ts got=%0d want=0", out_ts); end
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (level !== 3'd0) begin bad++; $display("FAIL mid_post_level got=%0d want=0", level); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_post_valid got=%0b want=0", out_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout bench did not finish got=running want=done");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_event();
    test_dual_channel();
    test_full_drop();
    test_flush();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
